usb_rx_bit_timing: RTL and testbench
====================================

// Module: usb_rx_bit_timing
// PURPOSE
//   Front end of the USB receive path, directly upstream of the EOP detector.
//   - Synchronizes the raw D+/D- pins and recovers bit timing from data edges.
//   - Issues the one-cycle sample strobe that the EOP detector and the decoder use as their enable.
//   - Delivers NRZI-decoded, bit-unstuffed data bits with stuff-error flagging to the RX controller.
// PARAMETERS
//   CLKS_PER_BIT  8   clk cycles per USB bit time (>=4)
//   SAMPLE_POINT  3   phase-counter value at which a bit is sampled (1..CLKS_PER_BIT-1)
//   STUFF_LEN     6   consecutive 1s after which the next bit is a stuffed 0
//   TIMEOUT_BITS  16  bit times without an edge before RUN falls back to IDLE
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   dp_raw       in   1  asynchronous D+ pin
//   dm_raw       in   1  asynchronous D- pin
//   dp_sync      out  1  synchronized D+ (to EOP detector dp_in)
//   dm_sync      out  1  synchronized D- (to EOP detector dm_in)
//   sample_en    out  1  one-cycle sample strobe (to EOP detector en)
//   bit_valid    out  1  bit_out carries a decoded, unstuffed data bit
//   bit_out      out  1  decoded data bit
//   stuff_error  out  1  one-cycle pulse: a 1 was received where a stuffed 0 was required
//   active       out  1  timing recovery is in the RUN state
// BEHAVIOUR
//   Reset (synchronous, active-high; rst dominates all other logic):
//     - Synchronizer flops and dp_sync load 1; dm_sync loads 0 (idle J).
//     - state=IDLE, phase=0, ones=0, last_dp=1, prev_se0=0.
//     - sample_en, bit_valid, bit_out, stuff_error and active are all 0.
//   Synchronizer: two flops per line. dp_sync/dm_sync are the second-stage outputs.
//   Edge: edge = dp_sync != dp_q, where dp_q is dp_sync delayed one cycle.
//   Phase counter and FSM:
//     - IDLE: phase is held at 0 and sample_en=0. On edge, go to RUN with phase<=1.
//     - RUN: phase <= (phase==CLKS_PER_BIT-1) ? 0 : phase+1.
//     - Resync in RUN: on edge, phase<=1, overriding the increment.
//     - sample_en is decoded combinationally: sample_en = (state==RUN && phase==SAMPLE_POINT).
//     - Edge and sample in the same cycle: the strobe still fires that cycle, and the resync takes effect on the next cycle.
//     - RUN -> IDLE when a strobe samples J (dp=1,dm=0) and prev_se0=1 (end of EOP).
//     - RUN -> IDLE when TIMEOUT_BITS*CLKS_PER_BIT clocks pass without an edge. The edge-timeout counter is cleared on every edge.
//     - active = (state==RUN).
//   Decode on each strobe (outputs are registered, latency 1 cycle after sample_en):
//     - SE0 (dp=0,dm=0):
//       - bit_valid<=0, ones<=0, prev_se0<=1.
//       - last_dp<=1, so the first bit after EOP/J decodes relative to J.
//     - Otherwise, with nrzi = (dp_sync==last_dp); last_dp<=dp_sync; prev_se0<=0:
//       - If ones==STUFF_LEN and nrzi==0: stuffed bit, so bit_valid<=0 and ones<=0.
//       - If ones==STUFF_LEN and nrzi==1: stuff_error<=1, bit_valid<=0, ones<=0.
//       - Else: bit_valid<=1, bit_out<=nrzi, ones <= nrzi ? ones+1 : 0.
//   bit_valid and stuff_error are single-cycle pulses and are 0 on all non-strobe cycles.
//   Entering IDLE clears ones, prev_se0 and the edge-timeout counter, and sets last_dp<=1.
//   rst asserted mid-packet: everything returns to reset values on the next edge. No partial bit is emitted.
//   Width rules:
//     - phase: clog2(CLKS_PER_BIT) bits.
//     - ones: clog2(STUFF_LEN+1) bits, saturating by construction.
//     - Edge-timeout counter: clog2(TIMEOUT_BITS*CLKS_PER_BIT+1) bits.
// TESTING
//   1. Reset, hold J 40 cycles -> active=0, sample_en never 1, dp_sync=1, dm_sync=0.
//   2. SYNC KJKJKJKK, 8 clk/bit -> first strobe 3 cycles after the first edge is seen on dp_sync. Decoded bits 0000000 then 1, with bit_valid one cycle after each strobe.
//   3. Payload of six 1s followed by a stuffed 0 -> six bit_valid=1/bit_out=1, stuffed bit dropped, no stuff_error. A seventh 1 instead -> stuff_error pulse, bit_valid=0.
//   4. Bit periods of 7 and 9 clocks alternating -> resync on each edge and no missed or duplicated strobes over 64 bits.
//   5. SE0,SE0,J after data -> two strobes with bit_valid=0, active drops to 0 the cycle after the J strobe, and the EOP detector sees the SE0 samples.
//   6. rst=1 mid-payload for one cycle -> all outputs 0, dp_sync=1, state IDLE. Then 20 bit times of J with no edge -> still IDLE. A single edge then a stuck line -> IDLE after 128 clocks.

Source files
------------

// File: rtl/usb_rx_bit_timing_if.sv
// Line-side and decoded-bit signals of the USB RX bit-timing front end.
interface usb_rx_bit_timing_if;
    logic dp_raw;
    logic dm_raw;
    logic dp_sync;
    logic dm_sync;
    logic sample_en;
    logic bit_valid;
    logic bit_out;
    logic stuff_error;
    logic active;

    modport master (
        output dp_raw, dm_raw,
        input  dp_sync, dm_sync, sample_en, bit_valid, bit_out, stuff_error, active
    );

    modport slave (
        input  dp_raw, dm_raw,
        output dp_sync, dm_sync, sample_en, bit_valid, bit_out, stuff_error, active
    );
endinterface

// File: rtl/usb_rx_bit_timing.sv
// USB RX front end: pin synchronizer, edge-locked bit timing, NRZI decode and
// bit unstuffing with stuff-error detection.
module usb_rx_bit_timing #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int STUFF_LEN    = 6,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    usb_rx_bit_timing_if.slave bus
);
    localparam int PW       = $clog2(CLKS_PER_BIT);
    localparam int OW       = $clog2(STUFF_LEN + 1);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_POINT);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LEN);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic          dp_s1, dp_s2, dm_s1, dm_s2, dp_q;
    logic [PW-1:0] phase, phase_nxt;
    logic [OW-1:0] ones, ones_nxt;
    logic [TW-1:0] to_cnt, to_nxt;
    logic          last_dp, last_dp_nxt;
    logic          prev_se0, prev_se0_nxt;
    logic          bit_valid_q, bit_valid_nxt;
    logic          bit_out_q, bit_out_nxt;
    logic          stuff_err_q, stuff_err_nxt;
    logic          edge_det, strobe, se0, nrzi, go_idle;

    // Sync flops reset to idle J so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_s1 <= 1'b1;
            dp_s2 <= 1'b1;
            dp_q  <= 1'b1;
            dm_s1 <= 1'b0;
            dm_s2 <= 1'b0;
        end else begin
            dp_s1 <= bus.dp_raw;
            dp_s2 <= dp_s1;
            dp_q  <= dp_s2;
            dm_s1 <= bus.dm_raw;
            dm_s2 <= dm_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            ones        <= '0;
            to_cnt      <= '0;
            last_dp     <= 1'b1;
            prev_se0    <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            ones        <= ones_nxt;
            to_cnt      <= to_nxt;
            last_dp     <= last_dp_nxt;
            prev_se0    <= prev_se0_nxt;
            bit_valid_q <= bit_valid_nxt;
            bit_out_q   <= bit_out_nxt;
            stuff_err_q <= stuff_err_nxt;
        end
    end

    assign edge_det = dp_s2 != dp_q;
    assign strobe   = (state == RUN) && (phase == PH_SAMPLE);
    assign se0      = !dp_s2 && !dm_s2;
    assign nrzi     = dp_s2 == last_dp;

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        ones_nxt      = ones;
        to_nxt        = to_cnt;
        last_dp_nxt   = last_dp;
        prev_se0_nxt  = prev_se0;
        bit_valid_nxt = 1'b0;
        bit_out_nxt   = bit_out_q;
        stuff_err_nxt = 1'b0;
        go_idle       = 1'b0;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                to_nxt    = '0;
                if (edge_det) begin
                    state_nxt = RUN;
                    phase_nxt = PW'(1);
                end
            end
            RUN: begin
                phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
                to_nxt    = to_cnt + 1'b1;
                // A sampling edge still strobes this cycle; the resync lands next cycle.
                if (edge_det) begin
                    phase_nxt = PW'(1);
                    to_nxt    = '0;
                end else if (to_cnt == TO_LAST) begin
                    go_idle = 1'b1;
                end
                if (strobe) begin
                    if (se0) begin
                        ones_nxt     = '0;
                        prev_se0_nxt = 1'b1;
                        last_dp_nxt  = 1'b1;
                    end else begin
                        last_dp_nxt  = dp_s2;
                        prev_se0_nxt = 1'b0;
                        if (ones == ONES_MAX) begin
                            ones_nxt      = '0;
                            stuff_err_nxt = nrzi;
                        end else begin
                            bit_valid_nxt = 1'b1;
                            bit_out_nxt   = nrzi;
                            ones_nxt      = nrzi ? ones + 1'b1 : '0;
                        end
                        if (dp_s2 && !dm_s2 && prev_se0) go_idle = 1'b1;
                    end
                end
                if (go_idle) begin
                    state_nxt    = IDLE;
                    phase_nxt    = '0;
                    ones_nxt     = '0;
                    to_nxt       = '0;
                    prev_se0_nxt = 1'b0;
                    last_dp_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.dp_sync     = dp_s2;
    assign bus.dm_sync     = dm_s2;
    assign bus.sample_en   = strobe;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.bit_out     = bit_out_q;
    assign bus.stuff_error = stuff_err_q;
    assign bus.active      = (state == RUN);
endmodule

// File: tb/tb_usb_rx_bit_timing.sv
// Randomized packet bench for usb_rx_bit_timing: line symbols are NRZI/stuff
// encoded here and decoded bit events are predicted at the bit level.
module tb_usb_rx_bit_timing;
  localparam int SE0 = 0, SJ = 1, SK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_rx_bit_timing_if bus();

  usb_rx_bit_timing #(
    .CLKS_PER_BIT(8), .SAMPLE_POINT(3), .STUFF_LEN(6), .TIMEOUT_BITS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int sym_q[$], exp_q[$], obs_q[$];
  bit lvl;
  int run;

  int n = 0, strobes = 0, se0_strobes = 0, all_strobes = 0, act_cycles = 0;
  int first_edge_n = -1, first_se_n = -1, last_se_n = -1, fall_n = -1, misalign = 0;
  bit armed = 1'b0;
  logic dps_prev = 1'b1, se_prev = 1'b0, act_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observes DUT outputs mid-cycle and records decoded events and timing marks.
  always @(negedge clk) begin
    n++;
    if (bus.sample_en) begin
      strobes++;
      all_strobes++;
      if (!bus.dp_sync && !bus.dm_sync) se0_strobes++;
      last_se_n = n;
      if (armed && first_se_n < 0) first_se_n = n;
    end
    if (armed && first_edge_n < 0 && bus.dp_sync != dps_prev) first_edge_n = n;
    if (bus.bit_valid || bus.stuff_error) begin
      if (!se_prev) misalign++;
      obs_q.push_back(bus.stuff_error ? (bus.bit_valid ? 3 : 2) : int'(bus.bit_out));
    end
    if (act_prev && !bus.active) fall_n = n;
    if (bus.active) act_cycles++;
    dps_prev = bus.dp_sync;
    se_prev  = bus.sample_en;
    act_prev = bus.active;
  end

  // Bit-level reference: NRZI decode, drop stuffed zeros, flag a 1 where a stuff was due.
  task automatic model();
    int last = 1, ones = 0, d, nz;
    exp_q.delete();
    foreach (sym_q[i]) begin
      if (sym_q[i] == SE0) begin
        ones = 0;
        last = 1;
      end else begin
        d    = (sym_q[i] == SJ) ? 1 : 0;
        nz   = (d == last) ? 1 : 0;
        last = d;
        if (ones == 6) begin
          if (nz == 1) exp_q.push_back(2);
          ones = 0;
        end else begin
          exp_q.push_back(nz);
          ones = (nz == 1) ? ones + 1 : 0;
        end
      end
    end
  endtask

  task automatic put_lvl();
    sym_q.push_back(lvl ? SJ : SK);
  endtask

  task automatic enc(input int b, input bit stuff);
    if (b == 0) begin
      lvl = !lvl;
      run = 0;
    end else begin
      run++;
    end
    put_lvl();
    if (stuff && run == 6) begin
      lvl = !lvl;
      run = 0;
      put_lvl();
    end
  endtask

  task automatic start_pkt();
    sym_q.delete();
    sym_q = '{SK, SJ, SK, SJ, SK, SJ, SK, SK};
    lvl = 1'b0;
    run = 1;
  endtask

  task automatic rand_bits(input int cnt, input int bias);
    for (int i = 0; i < cnt; i++)
      enc(bias ? int'(($urandom % 4) != 0) : int'($urandom % 2), 1'b1);
  endtask

  task automatic drive(input int mode, input int upto);
    for (int i = 0; i < upto; i++) begin
      bus.dp_raw = (sym_q[i] == SJ);
      bus.dm_raw = (sym_q[i] == SK);
      repeat (mode != 0 ? ((i % 2) != 0 ? 9 : 7) : 8) @(negedge clk);
    end
  endtask

  task automatic run_pkt(input string tag, input int mode);
    int m;
    sym_q.push_back(SE0);
    sym_q.push_back(SE0);
    sym_q.push_back(SJ);
    model();
    obs_q.delete();
    strobes = 0; se0_strobes = 0;
    first_edge_n = -1; first_se_n = -1; fall_n = -1;
    armed = 1'b1;
    drive(mode, sym_q.size());
    repeat (24) @(negedge clk);
    armed = 1'b0;
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_ev"}, obs_q[i], exp_q[i]);
    chk({tag, "_strobes"}, strobes, sym_q.size());
    chk({tag, "_se0_strobes"}, se0_strobes, 2);
    chk({tag, "_first_strobe"}, first_se_n - first_edge_n, 3);
    chk({tag, "_active_fall"}, fall_n - last_se_n, 1);
    chk({tag, "_active_end"}, bus.active, 0);
  endtask

  initial begin
    int cnt;
    bus.dp_raw = 1'b1;
    bus.dm_raw = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dp_sync", bus.dp_sync, 1);
    chk("rst_dm_sync", bus.dm_sync, 0);
    chk("rst_sample_en", bus.sample_en, 0);
    chk("rst_bit_valid", bus.bit_valid, 0);
    chk("rst_bit_out", bus.bit_out, 0);
    chk("rst_stuff_error", bus.stuff_error, 0);
    chk("rst_active", bus.active, 0);
    rst = 1'b0;
    all_strobes = 0; act_cycles = 0;
    repeat (40) @(negedge clk);
    chk("idle_strobes", all_strobes, 0);
    chk("idle_active", act_cycles, 0);
    chk("idle_dp_sync", bus.dp_sync, 1);
    chk("idle_dm_sync", bus.dm_sync, 0);

    start_pkt(); rand_bits(16, 1);
    run_pkt("sync", 0);

    start_pkt(); enc(0, 1'b1);
    for (int i = 0; i < 6; i++) enc(1, 1'b1);
    enc(0, 1'b1); rand_bits(8, 1);
    run_pkt("stuff", 0);

    start_pkt(); enc(0, 1'b1);
    for (int i = 0; i < 7; i++) enc(1, 1'b0);
    run = 0; rand_bits(8, 1);
    run_pkt("stuff_err", 0);

    start_pkt(); rand_bits(64, 0);
    run_pkt("jitter", 1);

    for (int p = 0; p < 3; p++) begin
      start_pkt(); rand_bits(10 + int'($urandom % 30), 1);
      run_pkt("rand", int'($urandom % 2));
    end

    // Reset in the middle of a payload, then a long quiet J, then a stuck line.
    start_pkt(); rand_bits(20, 1);
    drive(0, 14);
    rst = 1'b1;
    bus.dp_raw = 1'b1;
    bus.dm_raw = 1'b0;
    @(negedge clk);
    chk("mid_rst_active", bus.active, 0);
    chk("mid_rst_bit_valid", bus.bit_valid, 0);
    chk("mid_rst_bit_out", bus.bit_out, 0);
    chk("mid_rst_stuff_error", bus.stuff_error, 0);
    chk("mid_rst_sample_en", bus.sample_en, 0);
    chk("mid_rst_dp_sync", bus.dp_sync, 1);
    chk("mid_rst_dm_sync", bus.dm_sync, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_bit_valid", bus.bit_valid, 0);
    all_strobes = 0; act_cycles = 0;
    repeat (160) @(negedge clk);
    chk("quiet_strobes", all_strobes, 0);
    chk("quiet_active", act_cycles, 0);
    bus.dp_raw = 1'b0;
    bus.dm_raw = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.active) cnt++;
      else if (cnt > 0) break;
    end
    chk("timeout_run", cnt, 128);
    chk("timeout_active", bus.active, 0);
    chk("pulse_align", misalign, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
